// File: rtl/exhaustive_check_pkg.sv
// Shared types for the exhaustive vector checker: FSM state encoding and
// the result codes handed to the judge back-end parser.
package exhaustive_check_pkg;

    // Checker FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Result encodings understood by the back-end parser.
    typedef enum logic [1:0] {
        RES_PASS     = 2'd0,
        RES_MISMATCH = 2'd1,
        RES_TIMEOUT  = 2'd2
    } result_e;

    // Collapse the pass/timeout flags of a finished run into one result code.
    function automatic result_e result_of(input logic pass, input logic timeout);
        result_e res;
        if (pass) begin
            res = RES_PASS;
        end else if (timeout) begin
            res = RES_TIMEOUT;
        end else begin
            res = RES_MISMATCH;
        end
        return res;
    endfunction

endpackage

// File: rtl/vec_settle_timer.sv
// Settle down-counter (holds each vector for SETTLE cycles) and the run-budget
// up-counter that forces a timeout once MAX_CYCLES busy cycles have elapsed.
module vec_settle_timer #(
    parameter int SETTLE     = 2,
    parameter int MAX_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_settle,  // a new vector starts settling
    input  logic settle_en,    // FSM is in the settle state
    input  logic run_clear,    // a run is being accepted
    input  logic run_en,       // run in progress
    output logic settle_done,
    output logic budget_hit
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int RW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [RW-1:0] RUN_LAST    = RW'(MAX_CYCLES - 1);
    localparam logic [RW-1:0] RUN_MAX     = RW'(MAX_CYCLES);

    logic [SW-1:0] settle_cnt_r;
    logic [RW-1:0] run_cnt_r;

    // Settle down-counter: loaded at each new vector, counts down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= {SW{1'b0}};
        end else if (load_settle) begin
            settle_cnt_r <= SETTLE_LOAD;
        end else if (settle_en && (settle_cnt_r != {SW{1'b0}})) begin
            settle_cnt_r <= settle_cnt_r - SW'(1);
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    // Run-budget counter: cleared on start, counts busy cycles, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_r <= {RW{1'b0}};
        end else if (run_clear) begin
            run_cnt_r <= {RW{1'b0}};
        end else if (run_en && (run_cnt_r < RUN_MAX)) begin
            run_cnt_r <= run_cnt_r + RW'(1);
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    // The last settle cycle is the one that sees a zero count.
    assign settle_done = settle_en && (settle_cnt_r == {SW{1'b0}});

    // Budget is hit on the edge at which the counter would reach MAX_CYCLES,
    // so the forced DONE lands exactly MAX_CYCLES edges after start.
    assign budget_hit = run_en && (run_cnt_r >= RUN_LAST);

endmodule

// File: rtl/exhaustive_vector_checker.sv
// Exhaustive stimulus-and-check engine: walks every N_IN-bit vector in
// ascending order, holds it SETTLE cycles, compares dut_y against ref_y and
// stops at the first mismatch, after the last vector, or on budget expiry.
module exhaustive_vector_checker
    import exhaustive_check_pkg::*;
#(
    parameter int N_IN       = 3,
    parameter int N_OUT      = 1,
    parameter int SETTLE     = 2,
    parameter int MAX_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] dut_y,
    input  logic [N_OUT-1:0] ref_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [N_IN-1:0]  fail_vec,
    output logic [N_OUT-1:0] fail_dut,
    output logic [N_OUT-1:0] fail_ref
);

    localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};

    state_e           state_r, state_s;
    logic [N_IN-1:0]  stim_r, stim_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             pass_r, pass_s;
    logic             timeout_r, timeout_s;
    logic [N_IN-1:0]  fail_vec_r, fail_vec_s;
    logic [N_OUT-1:0] fail_dut_r, fail_dut_s;
    logic [N_OUT-1:0] fail_ref_r, fail_ref_s;

    logic             load_settle_s;
    logic             run_clear_s;
    logic             settle_en_s;
    logic             settle_done_s;
    logic             budget_hit_s;

    vec_settle_timer #(
        .SETTLE     (SETTLE),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_settle (load_settle_s),
        .settle_en   (settle_en_s),
        .run_clear   (run_clear_s),
        .run_en      (busy_r),
        .settle_done (settle_done_s),
        .budget_hit  (budget_hit_s)
    );

    assign settle_en_s = (state_r == ST_SETTLE);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            stim_r     <= {N_IN{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            timeout_r  <= 1'b0;
            fail_vec_r <= {N_IN{1'b0}};
            fail_dut_r <= {N_OUT{1'b0}};
            fail_ref_r <= {N_OUT{1'b0}};
        end else begin
            state_r    <= state_s;
            stim_r     <= stim_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            pass_r     <= pass_s;
            timeout_r  <= timeout_s;
            fail_vec_r <= fail_vec_s;
            fail_dut_r <= fail_dut_s;
            fail_ref_r <= fail_ref_s;
        end
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_s       = state_r;
        stim_s        = stim_r;
        busy_s        = busy_r;
        done_s        = done_r;
        pass_s        = pass_r;
        timeout_s     = timeout_r;
        fail_vec_s    = fail_vec_r;
        fail_dut_s    = fail_dut_r;
        fail_ref_s    = fail_ref_r;
        load_settle_s = 1'b0;
        run_clear_s   = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s       = ST_SETTLE;
                    stim_s        = {N_IN{1'b0}};
                    busy_s        = 1'b1;
                    done_s        = 1'b0;
                    pass_s        = 1'b0;
                    timeout_s     = 1'b0;
                    fail_vec_s    = {N_IN{1'b0}};
                    fail_dut_s    = {N_OUT{1'b0}};
                    fail_ref_s    = {N_OUT{1'b0}};
                    load_settle_s = 1'b1;
                    run_clear_s   = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end

            ST_SETTLE: begin
                if (budget_hit_s) begin
                    state_s    = ST_DONE;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                    pass_s     = 1'b0;
                    timeout_s  = 1'b1;
                    fail_vec_s = stim_r;
                    fail_dut_s = {N_OUT{1'b0}};
                    fail_ref_s = {N_OUT{1'b0}};
                end else if (settle_done_s) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_SETTLE;
                end
            end

            ST_CHECK: begin
                // A compare that resolves the run takes priority over the budget.
                if (dut_y != ref_y) begin
                    state_s    = ST_DONE;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                    pass_s     = 1'b0;
                    timeout_s  = 1'b0;
                    fail_vec_s = stim_r;
                    fail_dut_s = dut_y;
                    fail_ref_s = ref_y;
                end else if (stim_r == STIM_LAST) begin
                    state_s   = ST_DONE;
                    busy_s    = 1'b0;
                    done_s    = 1'b1;
                    pass_s    = 1'b1;
                    timeout_s = 1'b0;
                end else if (budget_hit_s) begin
                    state_s    = ST_DONE;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                    pass_s     = 1'b0;
                    timeout_s  = 1'b1;
                    fail_vec_s = stim_r;
                    fail_dut_s = {N_OUT{1'b0}};
                    fail_ref_s = {N_OUT{1'b0}};
                end else begin
                    state_s       = ST_SETTLE;
                    stim_s        = stim_r + N_IN'(1);
                    load_settle_s = 1'b1;
                end
            end

            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    assign stim     = stim_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign timeout  = timeout_r;
    assign fail_vec = fail_vec_r;
    assign fail_dut = fail_dut_r;
    assign fail_ref = fail_ref_r;

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Directed, table-driven bench for exhaustive_vector_checker. Instance A uses
// default parameters; instance B uses MAX_CYCLES=10 to exercise the timeout.
module tb_exhaustive_vector_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    int         mode = 0;

    logic [2:0] stim_a, stim_b, fvec_a, fvec_b;
    logic       dy_a, ry_a, dy_b, ry_b;
    logic       busy_a, done_a, pass_a, to_a, fdut_a, fref_a;
    logic       busy_b, done_b, pass_b, to_b, fdut_b, fref_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Problem-DUT / reference behaviour for each test mode.
    function automatic logic model_y(input int m, input logic [2:0] s, input bit is_ref);
        logic nand3;
        logic y;
        nand3 = ~&s;
        case (m)
            1:       y = is_ref ? nand3 : &s;
            2:       y = is_ref ? (nand3 & (s != 3'd5)) : nand3;
            default: y = nand3;
        endcase
        return y;
    endfunction

    always_comb begin
        dy_a = model_y(mode, stim_a, 1'b0);
        ry_a = model_y(mode, stim_a, 1'b1);
        dy_b = model_y(mode, stim_b, 1'b0);
        ry_b = model_y(mode, stim_b, 1'b1);
    end

    exhaustive_vector_checker u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a),
        .dut_y(dy_a), .ref_y(ry_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .timeout(to_a), .fail_vec(fvec_a),
        .fail_dut(fdut_a), .fail_ref(fref_a)
    );

    exhaustive_vector_checker #(.MAX_CYCLES(10)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b),
        .dut_y(dy_b), .ref_y(ry_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .timeout(to_b), .fail_vec(fvec_b),
        .fail_dut(fdut_b), .fail_ref(fref_b)
    );

    typedef struct {
        string name;
        int    mode;
        int    sel;
        int    exp_cyc;
        int    exp_pass;
        int    exp_to;
        int    exp_vec;
        int    exp_dut;
        int    exp_ref;
        int    exp_stim;
    } vec_t;

    vec_t rows[4];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_start(input int sel, input logic v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    function automatic logic sel_done(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    function automatic logic sel_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    function automatic int sel_stim(input int sel);
        return (sel == 0) ? int'(stim_a) : int'(stim_b);
    endfunction

    // Start pulse sampled on one rising edge (edge 0 of the run).
    task automatic pulse_start(input int sel);
        @(negedge clk);
        drive_start(sel, 1'b1);
        @(posedge clk);
        #1;
        drive_start(sel, 1'b0);
    endtask

    // Count edges after edge 0 until done; checks stim stepping while busy.
    // A second start is raised after edge inject_at (negative = never).
    task automatic wait_done(input int sel, input int inject_at, output int cycles);
        cycles = 0;
        while (cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            drive_start(sel, 1'b0);
            if (sel_done(sel)) break;
            chk("busy_during_run", int'(sel_busy(sel)), 1);
            chk("stim_step", sel_stim(sel), cycles / 3);
            if (cycles == inject_at) drive_start(sel, 1'b1);
        end
        if (!sel_done(sel)) chk("wait_done_budget", 0, 1);
    endtask

    task automatic run_row(input vec_t r, input int inject_at);
        int cyc;
        mode = r.mode;
        pulse_start(r.sel);
        wait_done(r.sel, inject_at, cyc);
        chk({r.name, "_cycles"}, cyc, r.exp_cyc);
        if (r.sel == 0) begin
            chk({r.name, "_busy"},  int'(busy_a), 0);
            chk({r.name, "_pass"},  int'(pass_a), r.exp_pass);
            chk({r.name, "_to"},    int'(to_a),   r.exp_to);
            chk({r.name, "_fvec"},  int'(fvec_a), r.exp_vec);
            chk({r.name, "_fdut"},  int'(fdut_a), r.exp_dut);
            chk({r.name, "_fref"},  int'(fref_a), r.exp_ref);
            chk({r.name, "_stim"},  int'(stim_a), r.exp_stim);
        end else begin
            chk({r.name, "_busy"},  int'(busy_b), 0);
            chk({r.name, "_pass"},  int'(pass_b), r.exp_pass);
            chk({r.name, "_to"},    int'(to_b),   r.exp_to);
            chk({r.name, "_fvec"},  int'(fvec_b), r.exp_vec);
            chk({r.name, "_fdut"},  int'(fdut_b), r.exp_dut);
            chk({r.name, "_fref"},  int'(fref_b), r.exp_ref);
            chk({r.name, "_stim"},  int'(stim_b), r.exp_stim);
        end
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_stim"}, int'(stim_a), 0);
        chk({tag, "_busy"}, int'(busy_a), 0);
        chk({tag, "_done"}, int'(done_a), 0);
        chk({tag, "_pass"}, int'(pass_a), 0);
        chk({tag, "_to"},   int'(to_a),   0);
        chk({tag, "_fvec"}, int'(fvec_a), 0);
        chk({tag, "_fdut"}, int'(fdut_a), 0);
        chk({tag, "_fref"}, int'(fref_a), 0);
    endtask

    initial begin
        int cyc;
        //            name        mode sel cyc pass to vec dut ref stim
        rows[0] = '{"full_pass",  0,   0,  24, 1,   0, 0,  0,  0,  7};
        rows[1] = '{"first_fail", 1,   0,  3,  0,   0, 0,  0,  1,  0};
        rows[2] = '{"mid_fail",   2,   0,  18, 0,   0, 5,  1,  0,  5};
        rows[3] = '{"budget",     0,   1,  10, 0,   1, 3,  0,  0,  3};

        // Reset state.
        #12;
        chk_a_zero("reset");
        chk("reset_b_busy", int'(busy_b), 0);
        chk("reset_b_done", int'(done_b), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_row(rows[i], -1);
        end

        // Asynchronous reset in the middle of a run.
        mode = 0;
        pulse_start(0);
        repeat (6) @(posedge clk);
        #1;
        chk("pre_reset_busy", int'(busy_a), 1);
        rst_n = 1'b0;
        #1;
        chk_a_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_row(rows[0], -1);

        // Second start while busy is ignored.
        run_row(rows[0], 5);

        // Start from DONE restarts at vector 0 and drops done.
        pulse_start(0);
        chk("restart_done", int'(done_a), 0);
        chk("restart_busy", int'(busy_a), 1);
        chk("restart_stim", int'(stim_a), 0);
        wait_done(0, -1, cyc);
        chk("restart_cycles", cyc, 24);
        chk("restart_pass", int'(pass_a), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
